// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg: shared constants and FSM state type for adc_capture_ctrl.
// Word layout: channel tag in the top CH_TAG_W bits, sample in the LSBs.
package adc_cap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    localparam int CH_TAG_W   = 3;
    localparam int SAMPLE_LSB = 0;

    localparam int TP_OFFSET  = 16;
    localparam int TP_STEP    = 1;

endpackage

// File: rtl/adc_capture_ctrl_sample_tick_gen.sv
// sample_tick_gen: programmable divider producing a one-cycle sample tick.
// load forces the next enabled cycle to tick; then one tick every div+1 cycles.
module sample_tick_gen #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == '0);

    // Down-counter reloaded with the period on every tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? div : cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: divider-timed multi-channel ADC capture and serialiser.
// Define ADC_TEST_PATTERN_EN to replace ad_in with internal per-channel ramps.
module adc_capture_ctrl
    import adc_cap_pkg::*;
#(
    parameter int CH_NUM = 2,
    parameter int ADC_W  = 8,
    parameter int OUT_W  = 16,
    parameter int CNT_W  = 32
) (
    input  logic                    Clk,
    input  logic                    reset_n,
    input  logic                    restart_req,
    input  logic [CNT_W-1:0]        div_set,
    input  logic [CNT_W-1:0]        number_data,
    input  logic [CH_NUM-1:0]       ch_mask,
    input  logic [CH_NUM*ADC_W-1:0] ad_in,
    input  logic                    fifo_full,
    output logic [OUT_W-1:0]        ad_out,
    output logic                    ad_out_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int TAG_MSB = OUT_W - 1;

    cap_state_t              state;
    logic [CNT_W-1:0]        div_sh;
    logic [CNT_W-1:0]        num_sh;
    logic [CNT_W-1:0]        smp_cnt;
    logic [CH_NUM-1:0]       mask_sh;
    logic [CH_NUM-1:0]       pend;
    logic [CH_NUM-1:0]       pend_rest;
    logic [CH_NUM*ADC_W-1:0] cap_reg;
    logic [CH_NUM*ADC_W-1:0] sample_src;
    logic [CH_TAG_W-1:0]     cur_ch;
    logic [ADC_W-1:0]        cur_smp;
    logic                    tick;
    logic                    tick_ok;
    logic                    emit;

    sample_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk   (Clk),
        .rst_n (reset_n),
        .load  (restart_req),
        .en    (state == ST_CAPTURE),
        .div   (div_sh),
        .tick  (tick)
    );

    // Channels still to emit after the current word
    assign pend_rest = pend & (pend - CH_NUM'(1));
    // A tick is usable only if no pass will still be running next cycle
    assign tick_ok   = tick && (pend_rest == '0);
    assign emit      = (|pend) && !restart_req;

    assign ad_out_valid = emit && !fifo_full;
    assign busy         = (state == ST_CAPTURE) || (state == ST_FLUSH);
    assign done         = (state == ST_DONE);

`ifdef ADC_TEST_PATTERN_EN
    logic [CH_NUM*ADC_W-1:0] ramp;
    logic [CH_NUM*ADC_W-1:0] ramp_base;

    // Start value of each channel's ramp
    always_comb begin
        ramp_base = '0;
        for (int i = 0; i < CH_NUM; i++)
            ramp_base[i*ADC_W +: ADC_W] = ADC_W'(i * TP_OFFSET);
    end

    // Ramps restart with each capture and advance once per tick
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            ramp <= '0;
        end else if (restart_req) begin
            ramp <= ramp_base;
        end else if (tick) begin
            for (int i = 0; i < CH_NUM; i++)
                ramp[i*ADC_W +: ADC_W] <=
                    ramp[i*ADC_W +: ADC_W] + ADC_W'(TP_STEP);
        end
    end

    assign sample_src = ramp;
`else
    assign sample_src = ad_in;
`endif

    // Lowest pending channel is the one emitted this cycle
    always_comb begin
        cur_ch  = '0;
        cur_smp = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (pend[i]) begin
                cur_ch  = CH_TAG_W'(i);
                cur_smp = cap_reg[i*ADC_W +: ADC_W];
            end
        end
    end

    // Tagged output word, zero when nothing is emitted
    always_comb begin
        ad_out = '0;
        if (emit) begin
            ad_out[TAG_MSB -: CH_TAG_W]    = cur_ch;
            ad_out[SAMPLE_LSB +: ADC_W]    = cur_smp;
        end
    end

    // Capture FSM, sample counter, serialiser and overflow flag
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            div_sh   <= '0;
            num_sh   <= '0;
            mask_sh  <= '0;
            smp_cnt  <= '0;
            pend     <= '0;
            cap_reg  <= '0;
            overflow <= 1'b0;
        end else if (restart_req) begin
            div_sh   <= div_set;
            num_sh   <= number_data;
            mask_sh  <= ch_mask;
            smp_cnt  <= '0;
            pend     <= '0;
            overflow <= 1'b0;
            if (number_data == '0 || ch_mask == '0)
                state <= ST_DONE;
            else
                state <= ST_CAPTURE;
        end else begin
            if (emit && fifo_full)
                overflow <= 1'b1;
            if (tick && !tick_ok)
                overflow <= 1'b1;
            if (tick_ok) begin
                cap_reg <= sample_src;
                pend    <= mask_sh;
            end else begin
                pend    <= pend_rest;
            end
            unique case (state)
                ST_CAPTURE: begin
                    if (tick) begin
                        smp_cnt <= smp_cnt + CNT_W'(1);
                        if (smp_cnt == num_sh - CNT_W'(1))
                            state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (pend_rest == '0)
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
